para_sequen_sched: RTL

- Synthesisable, clocked, multi-channel timed-write engine.
- One start command loads CH data words. Each word goes to its output register after a programmable number of clock cycles.
- Sequential mode (begin/end semantics): each delay is relative to the previous channel's write, so delays accumulate.
- Parallel mode (fork/join semantics): every delay is relative to start.
- Used as a self-checking stimulus and event sequencer in block-timing experiments.

---
 rtl/para_sequen_sched.sv | 112 +++++++++++
 1 files changed

// File: rtl/para_sequen_sched.sv
// Multi-channel timed-write engine: one start command schedules CH data words,
// each landing in its output register after a cumulative (sequential) or absolute (parallel) delay.
module para_sequen_sched #(
  parameter int CH = 4,
  parameter int DW = 4,
  parameter int TW = 8,
  parameter int AW = TW + $clog2(CH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             mode,
  input  logic [CH-1:0]    en_i,
  input  logic [CH*TW-1:0] delay_i,
  input  logic [CH*DW-1:0] data_i,
  output logic             busy,
  output logic             done,
  output logic [CH-1:0]    upd_o,
  output logic [CH*DW-1:0] data_o
);

  // Handshake: start is a level sampled on the rising edge only while IDLE;
  // there is no ready signal, busy=1 means start is ignored.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic [AW-1:0]    timer_q;
  logic [AW-1:0]    tmax_q, tmax_d;
  logic [AW-1:0]    target_q [CH];
  logic [AW-1:0]    target_d [CH];
  logic [CH-1:0]    en_q;
  logic [CH*DW-1:0] data_q;
  logic             last_evt;

  // Targets are computed from the live inputs so they are ready at the start edge.
  always_comb begin
    logic [AW-1:0] acc;
    acc    = '0;
    tmax_d = '0;
    for (int k = 0; k < CH; k++) begin
      target_d[k] = '0;
    end
    for (int k = 0; k < CH; k++) begin
      acc = acc + AW'(delay_i[k*TW +: TW]);
      if (mode) begin
        target_d[k] = AW'(delay_i[k*TW +: TW]);
        if (target_d[k] > tmax_d) tmax_d = target_d[k];
      end else begin
        target_d[k] = acc;
        tmax_d      = acc;
      end
    end
  end

  assign last_evt = (timer_q == tmax_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_evt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer_q <= '0;
      tmax_q  <= '0;
      en_q    <= '0;
      data_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      upd_o   <= '0;
      data_o  <= '0;
      for (int k = 0; k < CH; k++) target_q[k] <= '0;
    end else begin
      done  <= 1'b0;
      upd_o <= '0;
      if (state_q == IDLE) begin
        if (start) begin
          timer_q <= '0;
          tmax_q  <= tmax_d;
          en_q    <= en_i;
          data_q  <= data_i;
          busy    <= 1'b1;
          for (int k = 0; k < CH; k++) target_q[k] <= target_d[k];
        end
      end else begin
        timer_q <= timer_q + AW'(1);
        // Masked channels still reach their target; they just do not write.
        for (int k = 0; k < CH; k++) begin
          if (timer_q == target_q[k] && en_q[k]) begin
            data_o[k*DW +: DW] <= data_q[k*DW +: DW];
            upd_o[k]           <= 1'b1;
          end
        end
        if (last_evt) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
